// File: rtl/chain_vector_rf_if.sv
// Read/write port bundle for chain_vector_rf. The master drives the i_* request signals.
// The slave (the register file) drives the o_* response signals.
interface chain_vector_rf_if #(
  parameter int DATAW = 8,
  parameter int LANES = 40,
  parameter int ADDRW = 9
);
  logic [ADDRW-1:0]            i_raddr;
  logic                        i_rvalid;
  logic                        i_rload;
  logic [ADDRW-1:0]            i_waddr;
  logic [0:LANES-1][DATAW-1:0] i_wdata;
  logic [LANES-1:0]            i_wmask;
  logic                        i_wvalid;
  logic [0:LANES-1][DATAW-1:0] o_rdata;
  logic                        o_rvalid;
  logic                        o_rload;
  logic                        o_perr;

  modport master (
    output i_raddr, i_rvalid, i_rload, i_waddr, i_wdata, i_wmask, i_wvalid,
    input  o_rdata, o_rvalid, o_rload, o_perr
  );

  modport slave (
    input  i_raddr, i_rvalid, i_rload, i_waddr, i_wdata, i_wmask, i_wvalid,
    output o_rdata, o_rvalid, o_rload, o_perr
  );
endinterface

// File: rtl/chain_vector_rf.sv
// Lane-parallel vector register file: masked writes, same-cycle write-to-read forwarding, READ_LATENCY >= 2.
// Optional per-lane even parity is enabled by defining CHAIN_VRF_PARITY_EN.
module chain_vector_rf #(
  parameter int DATAW          = 8,
  parameter int LANES          = 40,
  parameter int LANES_PER_BRAM = 4,
  parameter int DEPTH          = 512,
  parameter int ADDRW          = $clog2(DEPTH),
  parameter int READ_LATENCY   = 2
) (
  input  logic             clk,
  input  logic             rst,
  chain_vector_rf_if.slave bus
);

  localparam int NUM_INST = (LANES + LANES_PER_BRAM - 1) / LANES_PER_BRAM;
  localparam int PADDED   = NUM_INST * LANES_PER_BRAM;
`ifdef CHAIN_VRF_PARITY_EN
  localparam int SLOTW    = DATAW + 1;
`else
  localparam int SLOTW    = DATAW;
`endif
  localparam int WORDW    = SLOTW * LANES_PER_BRAM;
  localparam int NSTAGE   = READ_LATENCY - 1;

  typedef logic [0:LANES-1][DATAW-1:0] vec_t;

  logic [ADDRW-1:0] waddr;
  logic [ADDRW-1:0] raddr;
  logic             wr_en;

  assign waddr = bus.i_waddr;
  assign raddr = bus.i_raddr;
  assign wr_en = bus.i_wvalid & ~rst;

  logic [SLOTW-1:0]  wr_slot [PADDED];
  logic [PADDED-1:0] wr_slot_en;
  logic [SLOTW-1:0]  rd_slot [LANES];

  genvar gi, gs;

  // Per-lane write slots; padding slots of the last instance are tied off.
  generate
    for (gi = 0; gi < PADDED; gi++) begin : g_lane
      if (gi < LANES) begin : g_used
`ifdef CHAIN_VRF_PARITY_EN
        assign wr_slot[gi] = {^bus.i_wdata[gi], bus.i_wdata[gi]};
`else
        assign wr_slot[gi] = bus.i_wdata[gi];
`endif
        assign wr_slot_en[gi] = wr_en & bus.i_wmask[gi];
      end else begin : g_pad
        assign wr_slot[gi]    = '0;
        assign wr_slot_en[gi] = 1'b0;
      end
    end
  endgenerate

  // One memory per LANES_PER_BRAM lanes, with a DATAW-granular slot write enable.
  generate
    for (gi = 0; gi < NUM_INST; gi++) begin : g_inst
      logic [WORDW-1:0] mem [DEPTH];
      logic [WORDW-1:0] rd_word_reg;

      always_ff @(posedge clk) begin
        for (int s = 0; s < LANES_PER_BRAM; s++) begin
          if (wr_slot_en[gi*LANES_PER_BRAM + s]) begin
            mem[waddr][s*SLOTW +: SLOTW] <= wr_slot[gi*LANES_PER_BRAM + s];
          end
        end
        if (bus.i_rvalid) begin
          rd_word_reg <= mem[raddr];
        end
      end

      for (gs = 0; gs < LANES_PER_BRAM; gs++) begin : g_slot
        if (gi*LANES_PER_BRAM + gs < LANES) begin : g_used
          assign rd_slot[gi*LANES_PER_BRAM + gs] = rd_word_reg[gs*SLOTW +: SLOTW];
        end else begin : g_pad
          logic [SLOTW-1:0] unused_pad_slot;
          assign unused_pad_slot = rd_word_reg[gs*SLOTW +: SLOTW];
        end
      end
    end
  endgenerate

  // Forwarding state travels beside the memory read so the merge is independent of read-during-write mode.
  logic             valid_s1_reg;
  logic             load_s1_reg;
  logic             hit_s1_reg;
  logic [LANES-1:0] fwd_mask_s1_reg;
  vec_t             fwd_data_s1_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_s1_reg    <= 1'b0;
      load_s1_reg     <= 1'b0;
      hit_s1_reg      <= 1'b0;
      fwd_mask_s1_reg <= '0;
      fwd_data_s1_reg <= '0;
    end else begin
      valid_s1_reg    <= bus.i_rvalid;
      load_s1_reg     <= bus.i_rload;
      hit_s1_reg      <= bus.i_rvalid & bus.i_wvalid & (raddr == waddr);
      fwd_mask_s1_reg <= bus.i_wmask;
      for (int n = 0; n < LANES; n++) begin
        fwd_data_s1_reg[n] <= bus.i_wmask[n] ? bus.i_wdata[n] : '0;
      end
    end
  end

  vec_t merged_data;
`ifdef CHAIN_VRF_PARITY_EN
  logic [LANES-1:0] lane_perr;
`endif

  generate
    for (gi = 0; gi < LANES; gi++) begin : g_merge
      logic use_fwd;
      assign use_fwd          = hit_s1_reg & fwd_mask_s1_reg[gi];
      assign merged_data[gi]  = use_fwd ? fwd_data_s1_reg[gi] : rd_slot[gi][DATAW-1:0];
`ifdef CHAIN_VRF_PARITY_EN
      // Stored data plus its parity bit must XOR to zero; forwarded lanes never flag.
      assign lane_perr[gi]    = ~use_fwd & (^rd_slot[gi]);
`endif
    end
  endgenerate

  // Output pipeline: data registers load only with a valid read, so o_rdata holds between reads.
  logic valid_pipe_reg [NSTAGE];
  logic load_pipe_reg  [NSTAGE];
  vec_t data_pipe_reg  [NSTAGE];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NSTAGE; k++) begin
        valid_pipe_reg[k] <= 1'b0;
        load_pipe_reg[k]  <= 1'b0;
        data_pipe_reg[k]  <= '0;
      end
    end else begin
      valid_pipe_reg[0] <= valid_s1_reg;
      load_pipe_reg[0]  <= load_s1_reg;
      if (valid_s1_reg) begin
        data_pipe_reg[0] <= merged_data;
      end
      for (int k = 1; k < NSTAGE; k++) begin
        valid_pipe_reg[k] <= valid_pipe_reg[k-1];
        load_pipe_reg[k]  <= load_pipe_reg[k-1];
        if (valid_pipe_reg[k-1]) begin
          data_pipe_reg[k] <= data_pipe_reg[k-1];
        end
      end
    end
  end

  assign bus.o_rvalid = valid_pipe_reg[NSTAGE-1];
  assign bus.o_rload  = load_pipe_reg[NSTAGE-1];
  assign bus.o_rdata  = data_pipe_reg[NSTAGE-1];

`ifdef CHAIN_VRF_PARITY_EN
  logic perr_pipe_reg [NSTAGE];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NSTAGE; k++) begin
        perr_pipe_reg[k] <= 1'b0;
      end
    end else begin
      perr_pipe_reg[0] <= valid_s1_reg & (|lane_perr);
      for (int k = 1; k < NSTAGE; k++) begin
        perr_pipe_reg[k] <= perr_pipe_reg[k-1];
      end
    end
  end

  assign bus.o_perr = perr_pipe_reg[NSTAGE-1];
`else
  assign bus.o_perr = 1'b0;
`endif

endmodule

// File: tb/tb_chain_vector_rf.sv
// Randomized self-checking bench for chain_vector_rf against an array-based memory model.
// Built with LANES=10 so the last memory instance is partially filled, and READ_LATENCY=4.
module tb_chain_vector_rf;

  localparam int DATAW = 8;
  localparam int LANES = 10;
  localparam int LPB   = 4;
  localparam int DEPTH = 512;
  localparam int ADDRW = $clog2(DEPTH);
  localparam int RL    = 4;
`ifdef CHAIN_VRF_PARITY_EN
  localparam int SLOTW = DATAW + 1;
`else
  localparam int SLOTW = DATAW;
`endif

  typedef logic [0:LANES-1][DATAW-1:0] vec_t;
  typedef struct {
    int   due;
    vec_t data;
    logic load;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  chain_vector_rf_if #(.DATAW(DATAW), .LANES(LANES), .ADDRW(ADDRW)) bus ();

  chain_vector_rf #(
    .DATAW(DATAW), .LANES(LANES), .LANES_PER_BRAM(LPB),
    .DEPTH(DEPTH), .ADDRW(ADDRW), .READ_LATENCY(RL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   checks   = 0;
  int   errors   = 0;
  int   edge_cnt = 0;
  vec_t model_mem [DEPTH];
  exp_t exp_q [$];
  vec_t last_rdata = '0;

  function automatic vec_t splat(input logic [DATAW-1:0] v);
    vec_t r;
    for (int n = 0; n < LANES; n++) r[n] = v;
    return r;
  endfunction

  // Drives one cycle of requests and updates the model: writes land first, then the read sees them.
  task automatic step(input logic wv, input logic [ADDRW-1:0] wa, input vec_t wd,
                      input logic [LANES-1:0] wm, input logic rv,
                      input logic [ADDRW-1:0] ra, input logic rl);
    exp_t e;
    bus.i_wvalid = wv;
    bus.i_waddr  = wa;
    bus.i_wdata  = wd;
    bus.i_wmask  = wm;
    bus.i_rvalid = rv;
    bus.i_raddr  = ra;
    bus.i_rload  = rl;
    @(posedge clk);
    edge_cnt++;
    if (rst) begin
      exp_q.delete();
      last_rdata = '0;
    end else begin
      if (wv) begin
        for (int n = 0; n < LANES; n++) if (wm[n]) model_mem[wa][n] = wd[n];
      end
      if (rv) begin
        e.due  = edge_cnt + RL - 1;
        e.data = model_mem[ra];
        e.load = rl;
        exp_q.push_back(e);
      end
    end
    #1;
  endtask

  task automatic idle();
    step(1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) idle();
    checks++; if (bus.o_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b expected 0", bus.o_rvalid); end
    checks++; if (bus.o_rload !== 1'b0) begin errors++; $display("FAIL reset_rload: got %b expected 0", bus.o_rload); end
    checks++; if (bus.o_perr !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b expected 0", bus.o_perr); end
    checks++; if (bus.o_rdata !== vec_t'(0)) begin errors++; $display("FAIL reset_rdata: got %h expected 0", bus.o_rdata); end
    rst = 1'b0;
    idle();
  endtask

  task automatic test_basic();
    vec_t wd;
    for (int n = 0; n < LANES; n++) wd[n] = DATAW'(n);
    step(1'b1, ADDRW'(5), wd, '1, 1'b0, '0, 1'b0);
    idle();
    step(1'b0, '0, '0, '0, 1'b1, ADDRW'(5), 1'b1);
    for (int j = 0; j < RL; j++) begin
      if (j > 0) idle();
      checks++;
      if (bus.o_rvalid !== (j == RL - 1)) begin
        errors++; $display("FAIL basic_latency: cycle %0d got rvalid %b expected %b", j, bus.o_rvalid, (j == RL - 1));
      end
    end
    checks++; if (bus.o_rdata !== wd) begin errors++; $display("FAIL basic_data: got %h expected %h", bus.o_rdata, wd); end
    checks++; if (bus.o_rload !== 1'b1) begin errors++; $display("FAIL basic_rload: got %b expected 1", bus.o_rload); end
    last_rdata = wd;
  endtask

  task automatic test_mask();
    vec_t expv;
    step(1'b1, ADDRW'(7), splat(8'hFF), '1, 1'b0, '0, 1'b0);
    step(1'b1, ADDRW'(7), splat(8'h03), LANES'(5), 1'b0, '0, 1'b0);
    step(1'b0, '0, '0, '0, 1'b1, ADDRW'(7), 1'b0);
    repeat (RL - 1) idle();
    for (int n = 0; n < LANES; n++) expv[n] = (n == 0 || n == 2) ? 8'h03 : 8'hFF;
    checks++; if (bus.o_rvalid !== 1'b1) begin errors++; $display("FAIL mask_rvalid: got %b expected 1", bus.o_rvalid); end
    checks++; if (bus.o_rdata !== expv) begin errors++; $display("FAIL mask_data: got %h expected %h", bus.o_rdata, expv); end
    checks++; if (bus.o_rload !== 1'b0) begin errors++; $display("FAIL mask_rload: got %b expected 0", bus.o_rload); end
    last_rdata = expv;
  endtask

  task automatic test_forward();
    vec_t expv;
    logic [LANES-1:0] lo_mask;
    for (int n = 0; n < LANES; n++) begin
      lo_mask[n] = (n < LANES / 2);
      expv[n]    = (n < LANES / 2) ? 8'h55 : 8'h11;
    end
    step(1'b1, ADDRW'(9), splat(8'h11), '1, 1'b0, '0, 1'b0);
    idle();
    step(1'b1, ADDRW'(9), splat(8'h55), lo_mask, 1'b1, ADDRW'(9), 1'b1);
    step(1'b1, ADDRW'(9), splat(8'h77), '1, 1'b0, '0, 1'b0);
    repeat (RL - 2) idle();
    checks++; if (bus.o_rvalid !== 1'b1) begin errors++; $display("FAIL fwd_rvalid: got %b expected 1", bus.o_rvalid); end
    checks++; if (bus.o_rdata !== expv) begin errors++; $display("FAIL fwd_data: got %h expected %h", bus.o_rdata, expv); end
    step(1'b0, '0, '0, '0, 1'b1, ADDRW'(9), 1'b0);
    repeat (RL - 1) idle();
    checks++; if (bus.o_rdata !== splat(8'h77)) begin errors++; $display("FAIL fwd_later_write: got %h expected %h", bus.o_rdata, splat(8'h77)); end
    last_rdata = splat(8'h77);
  endtask

  task automatic test_reset_inflight();
    step(1'b1, ADDRW'(11), splat(8'h22), '1, 1'b0, '0, 1'b0);
    step(1'b0, '0, '0, '0, 1'b1, ADDRW'(11), 1'b1);
    rst = 1'b1;
    step(1'b1, ADDRW'(11), splat(8'h33), '1, 1'b1, ADDRW'(12), 1'b1);
    rst = 1'b0;
    for (int j = 0; j < RL + 2; j++) begin
      idle();
      checks++; if (bus.o_rvalid !== 1'b0) begin errors++; $display("FAIL inflight_rvalid: cycle %0d got %b expected 0", j, bus.o_rvalid); end
      checks++; if (bus.o_rdata !== vec_t'(0)) begin errors++; $display("FAIL inflight_rdata: cycle %0d got %h expected 0", j, bus.o_rdata); end
    end
    step(1'b0, '0, '0, '0, 1'b1, ADDRW'(11), 1'b0);
    repeat (RL - 1) idle();
    checks++; if (bus.o_rvalid !== 1'b1) begin errors++; $display("FAIL rst_write_rvalid: got %b expected 1", bus.o_rvalid); end
    checks++; if (bus.o_rdata !== splat(8'h22)) begin errors++; $display("FAIL rst_write_ignored: got %h expected %h", bus.o_rdata, splat(8'h22)); end
    last_rdata = splat(8'h22);
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    vec_t wd;
    logic [LANES-1:0] wm;
    logic [ADDRW-1:0] wa, ra;
    exp_q.delete();
    for (int i = 0; i < 128 + RL; i++) begin
      if (i < 128) begin
        for (int n = 0; n < LANES; n++) wd[n] = DATAW'($urandom);
        if (i < 64) begin
          wa = ADDRW'(100 + i);
          wm = '1;
          ra = wa;
        end else begin
          wa = ADDRW'(100 + i - 64);
          wm = LANES'($urandom);
          ra = (i % 4 == 0) ? wa : ADDRW'(100 + $urandom_range(0, 63));
        end
        step(1'b1, wa, wd, wm, 1'b1, ra, 1'($urandom));
      end else begin
        idle();
      end
      if (bus.o_rvalid === 1'b1) pulses++;
      if (exp_q.size() > 0 && exp_q[0].due == edge_cnt) begin
        checks++; if (bus.o_rvalid !== 1'b1) begin errors++; $display("FAIL b2b_rvalid: step %0d got %b expected 1", i, bus.o_rvalid); end
        checks++; if (bus.o_rdata !== exp_q[0].data) begin errors++; $display("FAIL b2b_data: step %0d got %h expected %h", i, bus.o_rdata, exp_q[0].data); end
        checks++; if (bus.o_rload !== exp_q[0].load) begin errors++; $display("FAIL b2b_rload: step %0d got %b expected %b", i, bus.o_rload, exp_q[0].load); end
        last_rdata = exp_q[0].data;
        void'(exp_q.pop_front());
      end else begin
        checks++; if (bus.o_rvalid !== 1'b0) begin errors++; $display("FAIL b2b_idle_rvalid: step %0d got %b expected 0", i, bus.o_rvalid); end
        checks++; if (bus.o_rdata !== last_rdata) begin errors++; $display("FAIL b2b_hold: step %0d got %h expected %h", i, bus.o_rdata, last_rdata); end
      end
      checks++; if (bus.o_perr !== 1'b0) begin errors++; $display("FAIL b2b_perr: step %0d got %b expected 0", i, bus.o_perr); end
    end
    checks++; if (pulses != 128) begin errors++; $display("FAIL b2b_pulses: got %0d expected 128", pulses); end
  endtask

  task automatic test_parity();
    step(1'b1, ADDRW'(2), splat(8'h5A), '1, 1'b0, '0, 1'b0);
    idle();
`ifdef CHAIN_VRF_PARITY_EN
    dut.g_inst[0].mem[2][3*SLOTW] = ~dut.g_inst[0].mem[2][3*SLOTW];
    step(1'b0, '0, '0, '0, 1'b1, ADDRW'(2), 1'b0);
    repeat (RL - 1) idle();
    checks++; if (bus.o_rvalid !== 1'b1) begin errors++; $display("FAIL perr_rvalid: got %b expected 1", bus.o_rvalid); end
    checks++; if (bus.o_perr !== 1'b1) begin errors++; $display("FAIL perr_flag: got %b expected 1", bus.o_perr); end
    idle();
    checks++; if (bus.o_perr !== 1'b0) begin errors++; $display("FAIL perr_idle: got %b expected 0", bus.o_perr); end
    step(1'b1, ADDRW'(2), splat(8'h3C), '1, 1'b1, ADDRW'(2), 1'b0);
    repeat (RL - 1) idle();
    checks++; if (bus.o_perr !== 1'b0) begin errors++; $display("FAIL perr_forwarded: got %b expected 0", bus.o_perr); end
`endif
    step(1'b0, '0, '0, '0, 1'b1, ADDRW'(2), 1'b0);
    repeat (RL - 1) idle();
    checks++; if (bus.o_rvalid !== 1'b1) begin errors++; $display("FAIL clean_rvalid: got %b expected 1", bus.o_rvalid); end
    checks++; if (bus.o_perr !== 1'b0) begin errors++; $display("FAIL clean_perr: got %b expected 0", bus.o_perr); end
  endtask

  initial begin
    bus.i_raddr  = '0;
    bus.i_rvalid = 1'b0;
    bus.i_rload  = 1'b0;
    bus.i_waddr  = '0;
    bus.i_wdata  = '0;
    bus.i_wmask  = '0;
    bus.i_wvalid = 1'b0;
    test_reset();
    test_basic();
    test_mask();
    test_forward();
    test_reset_inflight();
    test_back_to_back();
    test_parity();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
